// File: rtl/sram_word_arbiter.sv
// Round-robin arbiter sharing a 2Kx8 SRAM between two 32-bit ports, one big-endian byte per cycle.
// Latency: gnt one cycle after req in IDLE, four byte cycles, done five cycles after req; 6 cycles/word.
module sram_word_arbiter #(
   parameter int SRAM_AW = 11,
   parameter int BYTE_W  = 8,
   localparam int WAW    = SRAM_AW - 2,
   localparam int WW     = 4 * BYTE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic               req1,
   input  logic               we0,
   input  logic               we1,
   input  logic [WAW-1:0]     addr0,
   input  logic [WAW-1:0]     addr1,
   input  logic [WW-1:0]      wdata0,
   input  logic [WW-1:0]      wdata1,
   output logic               gnt0,
   output logic               gnt1,
   output logic               done0,
   output logic               done1,
   output logic [WW-1:0]      rdata0,
   output logic [WW-1:0]      rdata1,
   output logic               busy,
   output logic               sram_nce,
   output logic               sram_re,
   output logic               sram_we,
   output logic [SRAM_AW-1:0] sram_addr,
   inout  wire  [BYTE_W-1:0]  sram_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic                port_q, port_d;
   logic                op_we_q, op_we_d;
   logic [WAW-1:0]      addr_q, addr_d;
   logic [WW-1:0]       wdata_q, wdata_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                last_q, last_d;
   logic [3*BYTE_W-1:0] rbuf_q, rbuf_d;
   logic                drv_q, drv_d;
   logic [BYTE_W-1:0]   wbyte_q, wbyte_d;
   logic                gnt0_d, gnt1_d, done0_d, done1_d, busy_d;
   logic [WW-1:0]       rdata0_d, rdata1_d;
   logic                nce_d, re_d, we_d;
   logic [SRAM_AW-1:0]  saddr_d;
   logic                sel;

   assign sram_data = drv_q ? wbyte_q : {BYTE_W{1'bz}};

   always_comb begin
      state_d  = state_q;
      port_d   = port_q;
      op_we_d  = op_we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      rbuf_d   = rbuf_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      rdata0_d = rdata0;
      rdata1_d = rdata1;
      nce_d    = 1'b1;
      re_d     = 1'b0;
      we_d     = 1'b0;
      saddr_d  = '0;
      drv_d    = 1'b0;
      wbyte_d  = '0;
      sel      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // Contention goes to the port that did not own the previous access.
               sel     = (req0 && req1) ? ~last_q : req1;
               port_d  = sel;
               op_we_d = sel ? we1 : we0;
               addr_d  = sel ? addr1 : addr0;
               wdata_d = sel ? wdata1 : wdata0;
               cnt_d   = 2'd0;
               gnt0_d  = ~sel;
               gnt1_d  = sel;
               state_d = ACCESS;
               nce_d   = 1'b0;
               re_d    = ~op_we_d;
               we_d    = op_we_d;
               saddr_d = {addr_d, 2'd0};
               drv_d   = op_we_d;
               wbyte_d = wdata_d[WW-1 -: BYTE_W];
            end
         end
         ACCESS: begin
            rbuf_d = {rbuf_q[2*BYTE_W-1:0], sram_data};
            if (cnt_q == 2'd3) begin
               state_d = DONE;
               done0_d = ~port_q;
               done1_d = port_q;
               if (!op_we_q) begin
                  if (port_q) rdata1_d = {rbuf_q, sram_data};
                  else        rdata0_d = {rbuf_q, sram_data};
               end
            end else begin
               cnt_d   = cnt_q + 2'd1;
               nce_d   = 1'b0;
               re_d    = ~op_we_q;
               we_d    = op_we_q;
               saddr_d = {addr_q, cnt_d};
               drv_d   = op_we_q;
               wbyte_d = wdata_q[BYTE_W*(3-int'(cnt_d)) +: BYTE_W];
            end
         end
         DONE: begin
            state_d = IDLE;
            last_d  = port_q;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         port_q    <= 1'b0;
         op_we_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= 2'd0;
         last_q    <= 1'b1;
         rbuf_q    <= '0;
         drv_q     <= 1'b0;
         wbyte_q   <= '0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         busy      <= 1'b0;
         sram_nce  <= 1'b1;
         sram_re   <= 1'b0;
         sram_we   <= 1'b0;
         sram_addr <= '0;
      end else begin
         state_q   <= state_d;
         port_q    <= port_d;
         op_we_q   <= op_we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         rbuf_q    <= rbuf_d;
         drv_q     <= drv_d;
         wbyte_q   <= wbyte_d;
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         done0     <= done0_d;
         done1     <= done1_d;
         rdata0    <= rdata0_d;
         rdata1    <= rdata1_d;
         busy      <= busy_d;
         sram_nce  <= nce_d;
         sram_re   <= re_d;
         sram_we   <= we_d;
         sram_addr <= saddr_d;
      end
   end

endmodule

// File: tb/tb_sram_word_arbiter.sv
// Bench for sram_word_arbiter: byte-array SRAM, word-level memory model and grant-order log.
module tb_sram_word_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [8:0]  addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, done0, done1, busy;
   logic [31:0] rdata0, rdata1;
   logic        sram_nce, sram_re, sram_we;
   logic [10:0] sram_addr;
   wire  [7:0]  sram_data;

   sram_word_arbiter #(.SRAM_AW(11), .BYTE_W(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .sram_nce(sram_nce), .sram_re(sram_re), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_data(sram_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 37 + 5);
   endfunction

   // Combinational-read SRAM that commits writes on the closing edge
   logic [7:0] mem [2048];
   initial for (int i = 0; i < 2048; i++) mem[i] = init_byte(i);
   assign sram_data = (!sram_nce && sram_re) ? mem[sram_addr] : 8'bz;
   always @(posedge clk) if (!sram_nce && sram_we) mem[sram_addr] <= sram_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int gport[$];
   int gcyc[$];
   bit both_seen = 1'b0;
   int done1_cnt = 0;
   always @(negedge clk) begin
      if (sram_re && sram_we) both_seen = 1'b1;
      if (gnt0) begin gport.push_back(0); gcyc.push_back(cyc); end
      if (gnt1) begin gport.push_back(1); gcyc.push_back(cyc); end
      if (done1) done1_cnt++;
   end

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_mem [2048];
   logic [31:0] last_rd [2];

   task automatic write_model(input logic [8:0] a, input logic [31:0] d);
      for (int i = 0; i < 4; i++) exp_mem[{a, 2'(i)}] = d[31-8*i -: 8];
   endtask

   function automatic logic [31:0] model_word(input logic [8:0] a);
      return {exp_mem[{a, 2'd0}], exp_mem[{a, 2'd1}], exp_mem[{a, 2'd2}], exp_mem[{a, 2'd3}]};
   endfunction

   task automatic set_req(input int p, input logic r, input logic w, input logic [8:0] a, input logic [31:0] d);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
   endtask

   // Single-access driver: records pin activity per cycle after req, no checking
   int          g_n, d_n;
   logic [31:0] rd;
   logic [10:0] log_addr [8];
   logic        log_re [8], log_we [8], log_nce [8];

   task automatic single(input int p, input logic w, input logic [8:0] a, input logic [31:0] d);
      int n;
      n = 0; g_n = -1; d_n = -1;
      set_req(p, 1'b1, w, a, d);
      while (d_n < 0 && n < 30) begin
         @(negedge clk);
         n++;
         if (n < 8) begin
            log_addr[n] = sram_addr; log_re[n] = sram_re; log_we[n] = sram_we; log_nce[n] = sram_nce;
         end
         if ((p == 0 ? gnt0 : gnt1) && g_n < 0) g_n = n;
         if (p == 0 ? done0 : done1) begin d_n = n; rd = (p == 0) ? rdata0 : rdata1; end
      end
      set_req(p, 1'b0, w, a, d);
      if (d_n > 0) begin
         if (w) write_model(a, d);
         else   last_rd[p] = model_word(a);
      end
   endtask

   // Requester process: random words, checks rdata against the memory model on every done
   task automatic run_port(input int p, input int nacc, input bit hold, input int amin, input int amax);
      logic        w;
      logic [8:0]  a;
      logic [31:0] d, got_rd;
      int          n;
      bit          got;
      for (int k = 0; k < nacc; k++) begin
         w = 1'($urandom_range(0, 1));
         a = 9'($urandom_range(amin, amax));
         d = $urandom;
         n = 0;
         got = 1'b0;
         set_req(p, 1'b1, w, a, d);
         while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (p == 0 ? done0 : done1) got = 1'b1;
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL port%0d_done_timeout: no done after %0d cycles, required done", p, n);
         end else begin
            got_rd = (p == 0) ? rdata0 : rdata1;
            if (w) write_model(a, d);
            else   last_rd[p] = model_word(a);
            if (got_rd !== last_rd[p]) begin
               errors++;
               $display("FAIL port%0d_rdata addr=%h: got %h, required %h", p, a, got_rd, last_rd[p]);
            end
         end
         if (!hold || k == nacc - 1) set_req(p, 1'b0, w, a, d);
         if (!hold && k < nacc - 1) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req0 = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({gnt0, gnt1, done0, done1} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b, required 0000", {gnt0, gnt1, done0, done1}); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h, required 0", rdata0); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h, required 0", rdata1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (sram_nce !== 1'b1) begin errors++; $display("FAIL reset_nce: got %b, required 1", sram_nce); end
      checks++; if ({sram_re, sram_we} !== 2'b00) begin errors++; $display("FAIL reset_re_we: got %b, required 00", {sram_re, sram_we}); end
      checks++; if (sram_addr !== 11'h0) begin errors++; $display("FAIL reset_addr: got %h, required 0", sram_addr); end
      req0 = 1'b0;
      reset = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      @(negedge clk);
   endtask

   task automatic test_write;
      logic [31:0] w;
      w = 32'hDEADBEEF;
      single(1, 1'b1, 9'h005, w);
      checks++; if (g_n !== 1) begin errors++; $display("FAIL wr_gnt_cycle: got %0d, required 1", g_n); end
      checks++; if (d_n !== 5) begin errors++; $display("FAIL wr_done_cycle: got %0d, required 5", d_n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({log_nce[i+1], log_re[i+1], log_we[i+1], log_addr[i+1]} !== {3'b001, 11'h014 + 11'(i)}) begin
            errors++;
            $display("FAIL wr_pins_byte%0d: nce/re/we/addr got %b%b%b/%h, required 001/%h",
                     i, log_nce[i+1], log_re[i+1], log_we[i+1], log_addr[i+1], 11'h014 + 11'(i));
         end
         checks++;
         if (mem[11'h014 + 11'(i)] !== w[31-8*i -: 8]) begin
            errors++;
            $display("FAIL wr_mem_byte%0d: got %h, required %h", i, mem[11'h014 + 11'(i)], w[31-8*i -: 8]);
         end
      end
      checks++; if (log_nce[5] !== 1'b1) begin errors++; $display("FAIL wr_done_pins_idle: nce got %b, required 1", log_nce[5]); end
      @(negedge clk);
   endtask

   task automatic test_read;
      single(0, 1'b0, 9'h005, 32'h0);
      checks++; if (g_n !== 1) begin errors++; $display("FAIL rd_gnt_cycle: got %0d, required 1", g_n); end
      checks++; if (d_n !== 5) begin errors++; $display("FAIL rd_done_cycle: got %0d, required 5", d_n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({log_re[i+1], log_we[i+1], log_addr[i+1]} !== {2'b10, 11'h014 + 11'(i)}) begin
            errors++;
            $display("FAIL rd_pins_byte%0d: re/we/addr got %b%b/%h, required 10/%h",
                     i, log_re[i+1], log_we[i+1], log_addr[i+1], 11'h014 + 11'(i));
         end
      end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata0: got %h, required deadbeef", rd); end
      @(negedge clk);
   endtask

   task automatic test_round_robin;
      int base;
      apply_reset();
      base = gport.size();
      fork
         run_port(0, 2, 1'b0, 0, 15);
         run_port(1, 2, 1'b0, 0, 15);
      join
      repeat (2) @(negedge clk);
      checks++;
      if (gport.size() !== base + 4) begin
         errors++;
         $display("FAIL rr_grant_count: got %0d, required 4", gport.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (gport[base+i] !== i % 2) begin errors++; $display("FAIL rr_order%0d: got port %0d, required %0d", i, gport[base+i], i % 2); end
         end
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (gcyc[base+i] - gcyc[base+i-1] !== 6) begin errors++; $display("FAIL rr_spacing%0d: got %0d, required 6", i, gcyc[base+i] - gcyc[base+i-1]); end
         end
      end
   endtask

   task automatic test_word_boundary;
      logic [31:0] w;
      logic [7:0]  b0;
      w = 32'h01020304;
      b0 = exp_mem[0];
      single(0, 1'b1, 9'h1FF, w);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[11'h7FC + 11'(i)] !== w[31-8*i -: 8]) begin
            errors++;
            $display("FAIL bnd_mem_byte%0d: got %h, required %h", i, mem[11'h7FC + 11'(i)], w[31-8*i -: 8]);
         end
      end
      checks++; if (log_addr[4] !== 11'h7FF) begin errors++; $display("FAIL bnd_last_addr: got %h, required 7ff", log_addr[4]); end
      checks++; if (mem[0] !== b0) begin errors++; $display("FAIL bnd_no_wrap: mem[0] got %h, required %h", mem[0], b0); end
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      int base;
      base = done1_cnt;
      set_req(1, 1'b1, 1'b1, 9'h010, 32'hAABBCCDD);
      repeat (2) @(negedge clk);
      // Reset taken at the edge that would open byte cycle 2
      checks++; if (sram_addr !== 11'h041 || sram_we !== 1'b1) begin errors++; $display("FAIL abort_byte1_pins: addr/we got %h/%b, required 041/1", sram_addr, sram_we); end
      reset = 1'b1;
      set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({sram_nce, sram_re, sram_we, busy, gnt1, done1} !== 6'b100000 || sram_addr !== 11'h0) begin
         errors++;
         $display("FAIL abort_pins_idle: nce/re/we/busy/gnt1/done1 got %b addr %h, required 100000 addr 000",
                  {sram_nce, sram_re, sram_we, busy, gnt1, done1}, sram_addr);
      end
      reset = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      repeat (8) @(negedge clk);
      checks++; if (done1_cnt !== base) begin errors++; $display("FAIL abort_no_done: got %0d done1 pulses, required 0", done1_cnt - base); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL abort_rdata1: got %h, required 0", rdata1); end
      exp_mem[11'h040] = 8'hAA;
      exp_mem[11'h041] = 8'hBB;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[11'h040 + 11'(i)] !== exp_mem[11'h040 + 11'(i)]) begin
            errors++;
            $display("FAIL abort_mem_byte%0d: got %h, required %h", i, mem[11'h040 + 11'(i)], exp_mem[11'h040 + 11'(i)]);
         end
      end
   endtask

   task automatic test_hold_fairness;
      int base;
      int exp_order [5];
      exp_order = '{0, 0, 1, 0, 1};
      base = gport.size();
      fork
         run_port(0, 3, 1'b1, 32, 47);
         begin
            repeat (8) @(negedge clk);
            run_port(1, 2, 1'b0, 32, 47);
         end
      join
      repeat (2) @(negedge clk);
      checks++;
      if (gport.size() !== base + 5) begin
         errors++;
         $display("FAIL fair_grant_count: got %0d, required 5", gport.size() - base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (gport[base+i] !== exp_order[i]) begin errors++; $display("FAIL fair_order%0d: got port %0d, required %0d", i, gport[base+i], exp_order[i]); end
         end
         for (int i = 1; i < 5; i++) begin
            checks++;
            if (gcyc[base+i] - gcyc[base+i-1] !== 6) begin errors++; $display("FAIL fair_spacing%0d: got %0d, required 6", i, gcyc[base+i] - gcyc[base+i-1]); end
         end
      end
   endtask

   task automatic test_random;
      int base;
      base = gport.size();
      fork
         run_port(0, 10, 1'($urandom_range(0, 1)), 500, 511);
         begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_port(1, 10, 1'b0, 500, 511);
         end
      join
      repeat (2) @(negedge clk);
      checks++;
      if (gport.size() !== base + 20) begin errors++; $display("FAIL rand_grant_count: got %0d, required 20", gport.size() - base); end
      for (int i = base + 1; i < gport.size(); i++) begin
         checks++;
         if (gcyc[i] - gcyc[i-1] < 6) begin errors++; $display("FAIL rand_spacing%0d: got %0d, required >= 6", i - base, gcyc[i] - gcyc[i-1]); end
      end
      checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL re_we_overlap: got 1, required 0"); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) exp_mem[i] = init_byte(i);
      last_rd[0] = '0;
      last_rd[1] = '0;
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_word_boundary();
      test_reset_abort();
      test_hold_fairness();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
